// File: rtl/input_shift_sequencer_if.sv
// rtl/input_shift_sequencer_if.sv - control/handshake bundle between sequencer and its environment
interface input_shift_sequencer_if #(
  parameter int CNT_W = 3
);
  logic             frame_start_i;
  logic             sample_strobe_i;
  logic             abort_i;
  logic             word_ready_i;
  logic             overrun_clr_i;
  logic             shift_en_o;
  logic             clear_en_o;
  logic             word_valid_o;
  logic             busy_o;
  logic             overrun_o;
  logic [CNT_W-1:0] sample_count_o;

  modport master (
    output frame_start_i, sample_strobe_i, abort_i, word_ready_i, overrun_clr_i,
    input  shift_en_o, clear_en_o, word_valid_o, busy_o, overrun_o, sample_count_o
  );

  modport slave (
    input  frame_start_i, sample_strobe_i, abort_i, word_ready_i, overrun_clr_i,
    output shift_en_o, clear_en_o, word_valid_o, busy_o, overrun_o, sample_count_o
  );
endinterface

// File: rtl/input_shift_sequencer.sv
// rtl/input_shift_sequencer.sv - frames capture words for the input bit shifter
module input_shift_sequencer #(
  parameter int SHIFT_DEPTH = 4,
  parameter int SHIFT_WIDTH = 4,
  parameter int CNT_W       = $clog2(SHIFT_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input_shift_sequencer_if.slave bus
);

  if (SHIFT_DEPTH < 2 || SHIFT_WIDTH < 1) begin : g_param_check
    $error("input_shift_sequencer: SHIFT_DEPTH must be >= 2 and SHIFT_WIDTH >= 1");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SHIFT_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             word_valid_q, word_valid_d;
  logic             shift_en, clear_en;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      word_valid_q <= word_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    shift_en  = 1'b0;
    clear_en  = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (!bus.abort_i && bus.frame_start_i) state_d = CLEAR;
        end
        CLEAR: begin
          clear_en = 1'b1;
          count_d  = '0;
          state_d  = CAPTURE;
        end
        CAPTURE: begin
          if (bus.abort_i) begin
            state_d = IDLE;
            count_d = '0;
          end else if (bus.frame_start_i) begin
            state_d = CLEAR;
            count_d = '0;
          end else if (bus.sample_strobe_i) begin
            shift_en = 1'b1;
            count_d  = count_q + CNT_W'(1);
            if (count_q == LAST_IDX) state_d = PRESENT;
          end
        end
        PRESENT: begin
          if (bus.abort_i) begin
            state_d = IDLE;
            count_d = '0;
          end else if (bus.word_ready_i) begin
            state_d = bus.frame_start_i ? CLEAR : IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
      // A strobe while the word is held is lost; the set outranks a same-cycle clear.
      if (state_q == PRESENT && bus.sample_strobe_i) overrun_d = 1'b1;
      else if (bus.overrun_clr_i)                    overrun_d = 1'b0;
    end
    word_valid_d = (state_d == PRESENT);
  end

  assign bus.shift_en_o     = shift_en;
  assign bus.clear_en_o     = clear_en;
  assign bus.word_valid_o   = word_valid_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.overrun_o      = overrun_q;
  assign bus.sample_count_o = count_q;

endmodule

// File: tb/tb_input_shift_sequencer.sv
// tb/tb_input_shift_sequencer.sv - directed and randomized bench for input_shift_sequencer
module tb_input_shift_sequencer;
  localparam int D     = 4;
  localparam int W     = 4;
  localparam int CNT_W = $clog2(D + 1);

  logic clk;
  logic async_rst_n;
  logic clk_en;

  input_shift_sequencer_if #(.CNT_W(CNT_W)) bus ();

  input_shift_sequencer #(
    .SHIFT_DEPTH(D),
    .SHIFT_WIDTH(W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .clk_en     (clk_en),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is "flushing", "filling" (holding m_cnt samples) or "full"; none = idle.
  logic m_flush, m_fill, m_full, m_ovr;
  int   m_cnt;

  always @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      m_flush <= 1'b0; m_fill <= 1'b0; m_full <= 1'b0; m_ovr <= 1'b0; m_cnt <= 0;
    end else if (clk_en) begin
      if (m_full && bus.sample_strobe_i) m_ovr <= 1'b1;
      else if (bus.overrun_clr_i)        m_ovr <= 1'b0;
      if (m_flush) begin
        m_flush <= 1'b0; m_fill <= 1'b1; m_cnt <= 0;
      end else if (m_fill) begin
        if (bus.abort_i) begin
          m_fill <= 1'b0; m_cnt <= 0;
        end else if (bus.frame_start_i) begin
          m_fill <= 1'b0; m_flush <= 1'b1; m_cnt <= 0;
        end else if (bus.sample_strobe_i) begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == D) begin
            m_fill <= 1'b0; m_full <= 1'b1;
          end
        end
      end else if (m_full) begin
        if (bus.abort_i || bus.word_ready_i) begin
          m_full  <= 1'b0;
          m_cnt   <= 0;
          m_flush <= !bus.abort_i && bus.frame_start_i;
        end
      end else if (!bus.abort_i && bus.frame_start_i) begin
        m_flush <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (async_rst_n) begin
      check("shift_en", int'(bus.shift_en_o),
            int'(clk_en && m_fill && bus.sample_strobe_i && !bus.abort_i && !bus.frame_start_i));
      check("clear_en", int'(bus.clear_en_o), int'(clk_en && m_flush));
      check("word_valid", int'(bus.word_valid_o), int'(m_full));
      check("busy", int'(bus.busy_o), int'(m_flush || m_fill || m_full));
      check("overrun", int'(bus.overrun_o), int'(m_ovr));
      check("count", int'(bus.sample_count_o), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    bus.frame_start_i = 0; bus.sample_strobe_i = 0; bus.abort_i = 0;
    bus.word_ready_i = 0;  bus.overrun_clr_i = 0;   clk_en = 1;
  endtask

  task automatic run_word();
    bus.frame_start_i = 1; tick(); bus.frame_start_i = 0;
    tick();
    bus.sample_strobe_i = 1;
    repeat (D) tick();
    bus.sample_strobe_i = 0;
  endtask

  int cyc;

  initial begin
    async_rst_n = 0;
    idle_inputs();
    repeat (3) tick();
    async_rst_n = 1;
    settle();
    check("rst_valid", int'(bus.word_valid_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_count", int'(bus.sample_count_o), 0);
    check("rst_shift_clear", int'(bus.shift_en_o) + int'(bus.clear_en_o), 0);
    tick();

    // Basic word
    bus.frame_start_i = 1; tick(); bus.frame_start_i = 0;
    settle();
    check("basic_clear_pulse", int'(bus.clear_en_o), 1);
    tick();
    for (int i = 0; i < D; i++) begin
      bus.sample_strobe_i = 1;
      settle();
      check("basic_shift", int'(bus.shift_en_o), 1);
      check("basic_count", int'(bus.sample_count_o), i);
      tick();
    end
    bus.sample_strobe_i = 0;
    settle();
    check("basic_valid", int'(bus.word_valid_o), 1);
    check("basic_full_count", int'(bus.sample_count_o), D);

    // Overrun while presented
    bus.sample_strobe_i = 1;
    settle();
    check("ovr_no_shift", int'(bus.shift_en_o), 0);
    tick(); tick();
    bus.sample_strobe_i = 0;
    check("ovr_set", int'(bus.overrun_o), 1);
    bus.word_ready_i = 1; tick(); bus.word_ready_i = 0;
    check("ovr_sticky", int'(bus.overrun_o), 1);
    check("take_valid_low", int'(bus.word_valid_o), 0);
    check("take_count_zero", int'(bus.sample_count_o), 0);
    bus.overrun_clr_i = 1; tick(); bus.overrun_clr_i = 0;
    check("ovr_clr", int'(bus.overrun_o), 0);
    run_word();
    bus.sample_strobe_i = 1; bus.overrun_clr_i = 1; tick();
    bus.sample_strobe_i = 0; bus.overrun_clr_i = 0;
    check("ovr_set_wins", int'(bus.overrun_o), 1);
    bus.word_ready_i = 1; bus.overrun_clr_i = 1; tick();
    bus.word_ready_i = 0; bus.overrun_clr_i = 0;

    // Restart and abort
    bus.frame_start_i = 1; tick(); bus.frame_start_i = 0; tick();
    bus.sample_strobe_i = 1; tick(); tick(); bus.sample_strobe_i = 0;
    check("restart_pre_count", int'(bus.sample_count_o), 2);
    bus.frame_start_i = 1; tick(); bus.frame_start_i = 0;
    settle();
    check("restart_clear", int'(bus.clear_en_o), 1);
    check("restart_count", int'(bus.sample_count_o), 0);
    tick();
    bus.sample_strobe_i = 1; bus.abort_i = 1;
    settle();
    check("abort_no_shift", int'(bus.shift_en_o), 0);
    tick();
    bus.sample_strobe_i = 0; bus.abort_i = 0;
    check("abort_idle", int'(bus.busy_o), 0);
    run_word();
    bus.abort_i = 1; tick(); bus.abort_i = 0;
    check("abort_present", int'(bus.word_valid_o), 0);

    // Back-to-back timing
    run_word();
    bus.word_ready_i = 1; bus.frame_start_i = 1; tick();
    bus.word_ready_i = 0; bus.frame_start_i = 0;
    settle();
    check("b2b_clear", int'(bus.clear_en_o), 1);
    cyc = 1;
    bus.sample_strobe_i = 1;
    while (!bus.word_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    bus.sample_strobe_i = 0;
    check("b2b_latency", cyc, D + 2);
    bus.word_ready_i = 1; tick(); bus.word_ready_i = 0;

    // Clock-enable gating mid-capture
    bus.frame_start_i = 1; tick(); bus.frame_start_i = 0; tick();
    bus.sample_strobe_i = 1; tick(); tick();
    clk_en = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("cen_no_shift", int'(bus.shift_en_o), 0);
      check("cen_count_hold", int'(bus.sample_count_o), 2);
      tick();
    end
    clk_en = 1;
    tick(); tick();
    bus.sample_strobe_i = 0;
    check("cen_complete", int'(bus.word_valid_o), 1);

    // Asynchronous reset while presenting with overrun set
    bus.sample_strobe_i = 1; tick(); bus.sample_strobe_i = 0;
    #1 async_rst_n = 0;
    #1;
    check("arst_valid", int'(bus.word_valid_o), 0);
    check("arst_busy", int'(bus.busy_o), 0);
    check("arst_ovr", int'(bus.overrun_o), 0);
    tick();
    async_rst_n = 1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      clk_en              = ($urandom_range(0, 9) != 0);
      bus.frame_start_i   = ($urandom_range(0, 9) == 0);
      bus.sample_strobe_i = ($urandom_range(0, 9) < 6);
      bus.abort_i         = ($urandom_range(0, 24) == 0);
      bus.word_ready_i    = ($urandom_range(0, 9) < 3);
      bus.overrun_clr_i   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 async_rst_n = 0;
        #1 check("rand_arst_busy", int'(bus.busy_o), 0);
        tick();
        async_rst_n = 1;
      end else begin
        tick();
      end
    end

    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
